ex_div_ctrl: RTL
================

# ex_div_ctrl

Multi-cycle integer divide sequencer for the execute stage. It accepts a RISC-V M-extension divide/remainder op, runs a radix-2 restoring division over 32 iterations, and drives a stall that freezes the ID/EX latch and upstream stages while it runs. It returns the result plus the destination register number with a one-cycle `done` pulse. It sits beside the single-cycle ALU, and the EX-stage result mux selects its output when `done` is high.

## Interface
- `WordSize`, default 32: operand and result width; the iteration count equals `WordSize`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  issue request; sampled only in IDLE
- `op`  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- `a`  in  WordSize  dividend (rs1)
- `b`  in  WordSize  divisor (rs2)
- `rdn_in`  in  5  destination register number
- `flush`  in  1  branch/exception kill; aborts the op in flight
- `stall`  out  1  holds ID/EX and earlier stages
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle result-valid pulse
- `result`  out  WordSize  quotient or remainder
- `rdn`  out  5  latched `rdn_in`

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, `start`=1 and `flush`=0:
  - Latch `op` and `rdn_in`.
  - Latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Record the quotient sign (a[msb]^b[msb]) and the remainder sign (a[msb]); both are forced to 0 for unsigned ops.
  - Clear the remainder register and the counter.
  - If a special case applies, load the final result and go to DONE. Otherwise go to CALC.
- Special cases, both taking the fast path:
  - b==0: quotient = all ones; remainder = a.
  - Signed ops with a==0x8000_0000 and b==0xFFFF_FFFF: quotient = 0x8000_0000; remainder = 0.
- CALC, once per cycle:
  - Shift {rem, quo} left 1.
  - Compute trial = rem − divisor at WordSize+1 bits.
  - If trial is non-negative, set rem = trial[WordSize-1:0] and set quo[0]=1.
  - The counter increments. After iteration `WordSize` (counter == WordSize−1), go to FIX.
- FIX:
  - Negate the quotient and/or remainder (two's complement, wrap modulo 2^WordSize) according to the recorded signs.
  - Select the quotient for DIV/DIVU and the remainder for REM/REMU into `result`.
  - Go to DONE.
- DONE: `done`=1 for exactly this cycle; go to IDLE. A `start` in DONE is ignored. The pipeline re-presents the next op after the stall drops.
- `flush`: in any non-IDLE state, go to IDLE next cycle with no `done`. A `flush` together with `start` in IDLE prevents the op from being accepted.
- `start` outside IDLE is ignored.
- `stall` = (IDLE & `start` & ~`flush`) | CALC | FIX. It is combinational from `start` in IDLE and registered-state-derived otherwise. It is low in DONE so that ID/EX advances on the same edge that `result` is consumed.

## Timing
- Reset values: state IDLE; `stall`, `busy`, `done` = 0; `result` = 0; `rdn` = 0; counter = 0.
- `rst` mid-operation returns the block to IDLE on the next edge and discards the result. `rst` has priority over `flush`, and `flush` over `start`.
- Normal latency: `start` sampled at edge 0 → CALC in cycles 1..32 → FIX in cycle 33 → `done` in cycle 34. `stall` is high from cycle 0 through 33.
- Special-case latency: `start` at edge 0 → `done` in cycle 1. `stall` is high in cycle 0 only.
- `result` and `rdn` are held stable from DONE until the next accepted `start`.
- Back-to-back ops: the earliest next accept is the IDLE cycle immediately after DONE, giving a throughput of one op per 35 cycles.

## Structure
- The shared package `ex_pkg` holds the `div_op_e` enum (DIV/DIVU/REM/REMU) and the `div_state_e` enum (IDLE/CALC/FIX/DONE). These are reused by the EX result mux and the hazard unit.
- One sub-module, `div_step`: a purely combinational single restoring iteration, taking (rem, quo, divisor) and producing (rem', quo'). It is instantiated once and registered by `ex_div_ctrl`.

## Test plan
- DIVU a=100, b=7, start one cycle → `stall` high for cycles 0–33, `done` in cycle 34, `result`=14; REMU with the same operands → 2.
- DIV a=−7 (0xFFFF_FFF9), b=2 → `result`=0xFFFF_FFFD (−3); REM → 0xFFFF_FFFF (−1); `rdn` equals the issued `rdn_in`=5.
- Divide by zero: DIVU a=42, b=0 → `done` in cycle 1, `result`=0xFFFF_FFFF; REM a=42, b=0 → 42.
- Overflow: DIV a=0x8000_0000, b=0xFFFF_FFFF → `done` in cycle 1, `result`=0x8000_0000; REM with the same operands → 0.
- Abort: `flush` asserted in cycle 10 of a DIVU → IDLE in cycle 11, `done` never asserts, `stall` is low from cycle 11. Repeat with `rst` in cycle 10 → all outputs at reset values.
- `start` held high through a whole op → exactly one `done`, then re-accept in the IDLE cycle after DONE with a second `done` 35 cycles after the first.

Source files
------------

// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared execute-stage types. The divide op encoding and the
//               divide sequencer state encoding are also used by the EX
//               result mux and the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    // M-extension divide/remainder ops, encoded as presented on the op port
    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    // Divide sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage : ex_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
//               {rem, quo} is shifted left by one; if the shifted remainder
//               is at least the divisor, the divisor is subtracted and a 1
//               is shifted into the quotient.
// Ports       : rem_i     - partial remainder (always < divisor_i)
//               quo_i     - dividend bits still to consume / quotient so far
//               divisor_i - divisor magnitude
//               rem_o     - next partial remainder
//               quo_o     - next quotient/dividend word
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WordSize = 32
) (
    input  logic [WordSize-1:0] rem_i,
    input  logic [WordSize-1:0] quo_i,
    input  logic [WordSize-1:0] divisor_i,
    output logic [WordSize-1:0] rem_o,
    output logic [WordSize-1:0] quo_o
);

    // The shifted remainder needs one extra bit: with an unsigned divisor
    // above 2^(WordSize-1) the partial remainder can have its msb set.
    logic [WordSize:0]   w_shifted;
    logic                w_ge;
    logic [WordSize-1:0] w_diff;

    assign w_shifted = {rem_i, quo_i[WordSize-1]};
    // Non-negative trial difference is the same as shifted >= divisor
    assign w_ge      = (w_shifted >= {1'b0, divisor_i});
    // When w_ge holds, the true difference is < divisor, so it fits in
    // WordSize bits and the modulo-2^WordSize subtraction is exact.
    assign w_diff    = w_shifted[WordSize-1:0] - divisor_i;

    always_comb begin
        rem_o = w_shifted[WordSize-1:0];
        quo_o = {quo_i[WordSize-2:0], 1'b0};
        if (w_ge) begin
            rem_o = w_diff;
            quo_o = {quo_i[WordSize-2:0], 1'b1};
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/ex_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_div_ctrl
// Description : Multi-cycle integer divide sequencer for the execute stage.
//               Radix-2 restoring division over WordSize iterations, with a
//               fast path for divide-by-zero and signed overflow. Stalls the
//               front of the pipeline while the op runs and pulses done for
//               one cycle with the result and destination register.
// Ports       : clk, rst  - rising-edge clock, synchronous active-high reset
//               start     - issue request (sampled only in IDLE)
//               op        - 0=DIV 1=DIVU 2=REM 3=REMU
//               a, b      - dividend (rs1), divisor (rs2)
//               rdn_in    - destination register number
//               flush     - aborts the op in flight
//               stall     - holds ID/EX and earlier stages
//               busy      - not IDLE
//               done      - one-cycle result-valid pulse
//               result    - quotient or remainder
//               rdn       - latched rdn_in
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div_ctrl
    import ex_pkg::*;
#(
    parameter int WordSize = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [WordSize-1:0] a,
    input  logic [WordSize-1:0] b,
    input  logic [4:0]          rdn_in,
    input  logic                flush,
    output logic                stall,
    output logic                busy,
    output logic                done,
    output logic [WordSize-1:0] result,
    output logic [4:0]          rdn
);

    localparam int            CW      = $clog2(WordSize);
    localparam logic [CW-1:0] LAST_IT = CW'(WordSize - 1);
    localparam logic [WordSize-1:0] MIN_NEG = {1'b1, {(WordSize-1){1'b0}}};

    div_state_e          state_q, state_d;
    div_op_e             op_q, op_d;
    logic [4:0]          rdn_q, rdn_d;
    logic [WordSize-1:0] divisor_q, divisor_d;
    logic [WordSize-1:0] quo_q, quo_d;
    logic [WordSize-1:0] rem_q, rem_d;
    logic [WordSize-1:0] result_q, result_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;

    // Issue-side decode
    div_op_e             w_op;
    logic                w_signed;
    logic                w_is_rem;
    logic [WordSize-1:0] w_a_mag;
    logic [WordSize-1:0] w_b_mag;
    logic                w_div0;
    logic                w_ovf;
    logic [WordSize-1:0] w_fast_res;

    assign w_op     = div_op_e'(op);
    assign w_signed = (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_is_rem = (w_op == OP_REM) || (w_op == OP_REMU);
    // Negating MIN_NEG yields MIN_NEG, which is its correct unsigned magnitude
    assign w_a_mag  = (w_signed && a[WordSize-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[WordSize-1]) ? -b : b;
    assign w_div0   = (b == '0);
    assign w_ovf    = w_signed && (a == MIN_NEG) && (b == '1);

    always_comb begin
        if (w_div0) begin
            w_fast_res = w_is_rem ? a : '1;
        end else begin
            // Signed overflow: quotient is the dividend itself, remainder 0
            w_fast_res = w_is_rem ? '0 : a;
        end
    end

    // Iteration datapath
    logic [WordSize-1:0] w_step_rem;
    logic [WordSize-1:0] w_step_quo;

    div_step #(
        .WordSize (WordSize)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (w_step_rem),
        .quo_o     (w_step_quo)
    );

    // Sign fix-up
    logic [WordSize-1:0] w_q_fix;
    logic [WordSize-1:0] w_r_fix;
    logic                w_op_is_rem;

    assign w_q_fix     = qneg_q ? -quo_q : quo_q;
    assign w_r_fix     = rneg_q ? -rem_q : rem_q;
    assign w_op_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rdn_d     = rdn_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d      = w_op;
                    rdn_d     = rdn_in;
                    divisor_d = w_b_mag;
                    quo_d     = w_a_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    qneg_d    = w_signed && (a[WordSize-1] ^ b[WordSize-1]);
                    rneg_d    = w_signed && a[WordSize-1];
                    if (w_div0 || w_ovf) begin
                        result_d = w_fast_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = w_step_rem;
                quo_d = w_step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = w_op_is_rem ? w_r_fix : w_q_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A killed op never publishes its result
        if ((state_q != S_IDLE) && flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_DIV;
            rdn_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rdn_q     <= rdn_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
        end
    end

    // Low in DONE so ID/EX advances on the edge that consumes result
    assign stall  = ((state_q == S_IDLE) && start && !flush)
                  || (state_q == S_CALC) || (state_q == S_FIX);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rdn    = rdn_q;

endmodule : ex_div_ctrl
`default_nettype wire
